// File: rtl/config_pkg.sv
// Shared configuration for the UART transmit path: FIFO sizing and baud divider.
package config_pkg;

    localparam int unsigned FifoAddrWidth = 4;
    localparam int unsigned UartClkDiv    = 868;

endpackage

// File: rtl/uart_baud_counter.sv
// Baud down-counter: load reloads ClkDiv-1, tick is high while the count is zero.
module uart_baud_counter #(
    parameter int unsigned ClkDiv = 868
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic tick
);

    localparam int unsigned CntW = $clog2(ClkDiv);

    logic [CntW-1:0] count;

    // Count down from ClkDiv-1 to zero after each load, then hold at zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= CntW'(ClkDiv - 1);
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    // One bit period ends on the cycle the count reaches zero.
    always_comb begin
        tick = (count == '0);
    end

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// UART transmit FIFO reader: pulls bytes from interleaved_memory and sends 8N1
// frames, LSB first. Define UART_TX_PARITY_EN to add an even-parity bit (8E1).
module uart_tx_fifo_reader
    import config_pkg::*;
#(
    parameter int unsigned FifoAddrWidth = config_pkg::FifoAddrWidth,
    parameter int unsigned ClkDiv        = UartClkDiv
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [FifoAddrWidth-1:0] wr_ptr,
    output logic [FifoAddrWidth-1:0] read_addr,
    input  logic [7:0]               mem_data,
    output logic [FifoAddrWidth-1:0] rd_ptr,
    output logic                     tx,
    output logic                     busy
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } tx_state_t;

    tx_state_t                state, state_nxt;
    logic [7:0]               shift, shift_nxt;
    logic [2:0]               bit_idx, bit_idx_nxt;
    logic [FifoAddrWidth-1:0] rd_nxt;
    logic                     empty;
    logic                     baud_load;
    logic                     baud_tick;
`ifdef UART_TX_PARITY_EN
    logic                     par, par_nxt;
`endif

    uart_baud_counter #(
        .ClkDiv (ClkDiv)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .load  (baud_load),
        .tick  (baud_tick)
    );

    assign empty     = (rd_ptr == wr_ptr);
    assign read_addr = rd_ptr;

    // State, shift register, bit index and read pointer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            shift   <= '0;
            bit_idx <= '0;
            rd_ptr  <= '0;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            shift   <= shift_nxt;
            bit_idx <= bit_idx_nxt;
            rd_ptr  <= rd_nxt;
`ifdef UART_TX_PARITY_EN
            par     <= par_nxt;
`endif
        end
    end

    // Next-state logic and line outputs; baud counter reloads on entry to each bit.
    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift;
        bit_idx_nxt = bit_idx;
        rd_nxt      = rd_ptr;
        baud_load   = 1'b0;
        tx          = 1'b1;
        busy        = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_nxt     = par;
`endif
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (enable && !empty) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                state_nxt = LOAD;
            end
            LOAD: begin
                shift_nxt   = mem_data;
                bit_idx_nxt = '0;
                rd_nxt      = rd_ptr + 1'b1;
                baud_load   = 1'b1;
                state_nxt   = START;
`ifdef UART_TX_PARITY_EN
                par_nxt     = ^mem_data;
`endif
            end
            START: begin
                tx = 1'b0;
                if (baud_tick) begin
                    baud_load = 1'b1;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                tx = shift[0];
                if (baud_tick) begin
                    baud_load = 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end else begin
                        shift_nxt   = {1'b0, shift[7:1]};
                        bit_idx_nxt = bit_idx + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx = par;
                if (baud_tick) begin
                    baud_load = 1'b1;
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_tick) begin
                    state_nxt = (enable && !empty) ? FETCH : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
